// File: rtl/rc4_search_pkg.sv
// rtl/rc4_search_pkg.sv - shared types and constants for the RC4 key-search dispatcher
//
// Purpose: FSM state encoding, default search geometry and the key type used by
//          rc4_key_dispatcher and its round-robin arbiter.
// Ports:   none (package).

package rc4_search_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    FOUND,
    EXHAUSTED
  } dispatch_state_t;

  // Default geometry; the dispatcher overrides these through its own parameters.
  localparam int KEY_WIDTH_DEFAULT = 24;
  localparam int CHUNK_LOG_DEFAULT = 12;
  localparam int CHUNK_SIZE        = 1 << CHUNK_LOG_DEFAULT;

  typedef logic [KEY_WIDTH_DEFAULT-1:0] key_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter granting at most one requester per cycle
//
// Purpose: picks the first asserted request at or after the rotating pointer.
//          On advance the pointer moves to winner+1, wrapping at N.
// Ports:
//   clk        in   1        clock
//   rst        in   1        async active-high reset; pointer returns to 0
//   req        in   N        request vector
//   advance    in   1        grant was consumed; rotate pointer past the winner
//   grant      out  N        one-hot grant (all zero when no request)
//   grant_idx  out  IDX_W    index of the granted requester

module rr_arbiter #(
  parameter  int N     = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;

  // Walk the rotation from the far end back to the pointer so the requester
  // closest to the pointer is the last one written and therefore wins.
  always_comb begin
    int j;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) grant_idx = IDX_W'(j);
    end
    grant = (|req) ? (N'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rc4_key_dispatcher.sv
// rtl/rc4_key_dispatcher.sv - dynamic chunk dispatcher for a multicore RC4 key search
//
// Purpose: hands keys 0..KEY_MAX out in 2^CHUNK_LOG-key chunks to whichever core
//          is idle, latches the first winning key/core and broadcasts a kill.
// Optional: define KEY_DISPATCH_PERF_EN to build the busy-cycle and chunk counters;
//           without it perf_cycles and perf_chunks are constant 0.
// Ports:
//   clk, reset            clock; async active-high reset
//   start, abort          one-cycle command pulses
//   core_ready            per-core idle/request level
//   core_hit              per-core hit pulse
//   core_hit_key          per-core tested key, packed core 0 in the low bits
//   core_load             one-hot chunk assignment pulse
//   core_key_lower/upper  chunk bounds, valid with core_load
//   core_kill             one-cycle kill broadcast
//   busy                  DISPATCH or DRAIN
//   found, found_key, found_core   sticky search result
//   exhausted             sticky; space searched with no hit
//   perf_cycles, perf_chunks       optional counters

module rc4_key_dispatcher
  import rc4_search_pkg::*;
#(
  parameter  int                   NUM_CORES = 8,
  parameter  int                   KEY_WIDTH = 24,
  parameter  int                   CHUNK_LOG = 12,
  parameter  logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF,
  localparam int                   IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_CORES-1:0]           core_ready,
  input  logic [NUM_CORES-1:0]           core_hit,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] core_hit_key,
  output logic [NUM_CORES-1:0]           core_load,
  output logic [KEY_WIDTH-1:0]           core_key_lower,
  output logic [KEY_WIDTH-1:0]           core_key_upper,
  output logic                           core_kill,
  output logic                           busy,
  output logic                           found,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [IDX_W-1:0]               found_core,
  output logic                           exhausted,
  output logic [31:0]                    perf_cycles,
  output logic [KEY_WIDTH-1:0]           perf_chunks
);

  // base carries one extra bit so stepping past 2^KEY_WIDTH-1 is seen as
  // "beyond KEY_MAX" instead of wrapping back to key 0.
  localparam logic [KEY_WIDTH:0] CHUNK_SPAN = (KEY_WIDTH + 1)'(1) << CHUNK_LOG;
  localparam logic [KEY_WIDTH:0] CHUNK_LAST = CHUNK_SPAN - (KEY_WIDTH + 1)'(1);
  localparam logic [KEY_WIDTH:0] LIMIT      = {1'b0, KEY_MAX};

  dispatch_state_t        state;
  logic [KEY_WIDTH:0]     base;
  logic [KEY_WIDTH:0]     base_next;
  logic [KEY_WIDTH:0]     chunk_end;
  logic [NUM_CORES-1:0]   loaded;
  logic [NUM_CORES-1:0]   req;
  logic [NUM_CORES-1:0]   grant;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       hit_idx;
  logic                   any_hit;
  logic                   active;
  logic                   pick;

  assign active    = (state == DISPATCH) || (state == DRAIN);
  assign busy      = active;
  assign any_hit   = |core_hit;
  assign base_next = base + CHUNK_SPAN;
  assign chunk_end = base + CHUNK_LAST;

  // A hit or abort owns the cycle, so the arbiter sees no requests then.
  assign req  = (state == DISPATCH && !any_hit && !abort) ? (core_ready & ~loaded) : '0;
  assign pick = |grant;

  // Lowest-index hitter wins a simultaneous hit.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_hit[i]) hit_idx = IDX_W'(i);
    end
  end

  rr_arbiter #(
    .N (NUM_CORES)
  ) u_arbiter (
    .clk       (clk),
    .rst       (reset),
    .req       (req),
    .advance   (pick),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      base           <= '0;
      loaded         <= '0;
      core_load      <= '0;
      core_key_lower <= '0;
      core_key_upper <= '0;
      core_kill      <= 1'b0;
      found          <= 1'b0;
      found_key      <= '0;
      found_core     <= '0;
      exhausted      <= 1'b0;
    end else begin
      core_load <= '0;
      core_kill <= 1'b0;
      // A core forgets its chunk mark as soon as it releases ready.
      loaded    <= loaded & core_ready;

      case (state)
        IDLE, FOUND, EXHAUSTED: begin
          if (start) begin
            found     <= 1'b0;
            exhausted <= 1'b0;
            base      <= '0;
            state     <= DISPATCH;
          end
        end

        DISPATCH, DRAIN: begin
          if (any_hit) begin
            found      <= 1'b1;
            found_key  <= core_hit_key[int'(hit_idx)*KEY_WIDTH +: KEY_WIDTH];
            found_core <= hit_idx;
            core_kill  <= 1'b1;
            state      <= FOUND;
          end else if (abort) begin
            core_kill <= 1'b1;
            state     <= IDLE;
          end else if (state == DISPATCH) begin
            if (pick) begin
              core_load      <= grant;
              loaded         <= (loaded & core_ready) | grant;
              core_key_lower <= base[KEY_WIDTH-1:0];
              core_key_upper <= (chunk_end > LIMIT) ? KEY_MAX : chunk_end[KEY_WIDTH-1:0];
              base           <= base_next;
              if (base_next > LIMIT) state <= DRAIN;
            end
          end else if (&(core_ready & ~loaded)) begin
            // Every core is idle and holds no chunk: the space is done.
            exhausted <= 1'b1;
            state     <= EXHAUSTED;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEY_DISPATCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cycles <= '0;
      perf_chunks <= '0;
    end else if (start && !active) begin
      perf_cycles <= '0;
      perf_chunks <= '0;
    end else begin
      if (active && perf_cycles != 32'hFFFF_FFFF) perf_cycles <= perf_cycles + 32'd1;
      if (pick) perf_chunks <= perf_chunks + 1'b1;
    end
  end
`else
  assign perf_cycles = '0;
  assign perf_chunks = '0;
`endif

endmodule

// File: tb/tb_rc4_key_dispatcher.sv
// tb/tb_rc4_key_dispatcher.sv - scoreboard bench for rc4_key_dispatcher

module tb_rc4_key_dispatcher;

  localparam int ND = 3;
  localparam int NC = 4;
  localparam int KW = 24;
  localparam int                CL_TAB [ND] = '{4, 4, 20};
  localparam logic [KW-1:0]     KM_TAB [ND] = '{24'h00003F, 24'h000038, 24'hFFFFFF};

  typedef struct {
    longint unsigned lo;
    longint unsigned hi;
  } chunk_t;

  typedef struct {
    bit              is_hit;
    longint unsigned key;
    int              core;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic              start      [ND];
  logic              abort      [ND];
  logic [NC-1:0]     ready      [ND];
  logic [NC-1:0]     hit        [ND];
  logic [NC*KW-1:0]  hit_key    [ND];
  logic [NC-1:0]     load       [ND];
  logic [KW-1:0]     lower      [ND];
  logic [KW-1:0]     upper      [ND];
  logic              kill       [ND];
  logic              busy       [ND];
  logic              found      [ND];
  logic [KW-1:0]     found_key  [ND];
  logic [1:0]        found_core [ND];
  logic              exhausted  [ND];
  logic [31:0]       perf_cycles[ND];
  logic [KW-1:0]     perf_chunks[ND];

  chunk_t exp_chunk [ND][$];
  res_t   exp_res   [ND][$];
  int     log_core[$];
  int     log_cyc[$];
  int     cm_mode [ND];
  int     held [ND][NC];
  int     cnt  [ND][NC];
  int     off  [ND][NC];
  bit     prev_kill [ND];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    rc4_key_dispatcher #(
      .NUM_CORES (NC),
      .KEY_WIDTH (KW),
      .CHUNK_LOG (CL_TAB[g]),
      .KEY_MAX   (KM_TAB[g])
    ) dut (
      .clk            (clk),
      .reset          (rst),
      .start          (start[g]),
      .abort          (abort[g]),
      .core_ready     (ready[g]),
      .core_hit       (hit[g]),
      .core_hit_key   (hit_key[g]),
      .core_load      (load[g]),
      .core_key_lower (lower[g]),
      .core_key_upper (upper[g]),
      .core_kill      (kill[g]),
      .busy           (busy[g]),
      .found          (found[g]),
      .found_key      (found_key[g]),
      .found_core     (found_core[g]),
      .exhausted      (exhausted[g]),
      .perf_cycles    (perf_cycles[g]),
      .perf_chunks    (perf_chunks[g])
    );
  end

  task automatic chk_eq(input string name, input int d, input longint unsigned act,
                        input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h", name, d, act, exp);
    end
  endtask

  // Monitor / scoreboard: consumes loads and kills as the DUTs present them.
  always @(posedge clk) begin
    chunk_t c;
    res_t   r;
    #1;
    for (int d = 0; d < ND; d++) begin
      if (load[d] != '0) begin
        chk_eq("load_onehot", d, $countones(load[d]), 1);
        chk_eq("load_after_found", d, found[d], 0);
        if (exp_chunk[d].size() == 0) begin
          chk_eq("unexpected_load", d, load[d], 0);
        end else begin
          c = exp_chunk[d].pop_front();
          chk_eq("chunk_lower", d, lower[d], c.lo);
          chk_eq("chunk_upper", d, upper[d], c.hi);
        end
        if (d == 0) begin
          log_core.push_back($clog2(load[d]));
          log_cyc.push_back(cyc);
        end
      end
      if (kill[d]) begin
        chk_eq("kill_one_cycle", d, prev_kill[d], 0);
        if (exp_res[d].size() == 0) begin
          chk_eq("unexpected_kill", d, kill[d], 0);
        end else begin
          r = exp_res[d].pop_front();
          chk_eq("kill_busy", d, busy[d], 0);
          chk_eq("kill_exhausted", d, exhausted[d], 0);
          chk_eq("kill_found", d, found[d], r.is_hit);
          if (r.is_hit) begin
            chk_eq("found_key", d, found_key[d], r.key);
            chk_eq("found_core", d, found_core[d], r.core);
          end
        end
      end
      prev_kill[d] = kill[d];
    end
  end

  // Core model: mode 0 holds ready high, mode 2 holds it low, mode 1 works a
  // chunk for a few cycles, releases ready, then asks again.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < NC; i++) begin
        if (cm_mode[d] == 0 || cm_mode[d] == 2) begin
          ready[d][i] = (cm_mode[d] == 0);
          held[d][i]  = 0;
          cnt[d][i]   = 0;
          off[d][i]   = 0;
        end else if (load[d][i]) begin
          chk_eq("reload_busy_core", d, held[d][i], 0);
          held[d][i] = 1;
          cnt[d][i]  = int'($urandom_range(1, 4));
        end else if (held[d][i] != 0) begin
          cnt[d][i]--;
          if (cnt[d][i] == 0) begin
            held[d][i]  = 0;
            ready[d][i] = 1'b0;
            off[d][i]   = int'($urandom_range(1, 3));
          end
        end else if (!ready[d][i]) begin
          off[d][i]--;
          if (off[d][i] <= 0) ready[d][i] = 1'b1;
        end
      end
    end
  end

  task automatic check_zero(input int d);
    chk_eq("rst_load", d, load[d], 0);
    chk_eq("rst_lower", d, lower[d], 0);
    chk_eq("rst_upper", d, upper[d], 0);
    chk_eq("rst_kill", d, kill[d], 0);
    chk_eq("rst_busy", d, busy[d], 0);
    chk_eq("rst_found", d, found[d], 0);
    chk_eq("rst_found_key", d, found_key[d], 0);
    chk_eq("rst_found_core", d, found_core[d], 0);
    chk_eq("rst_exhausted", d, exhausted[d], 0);
    chk_eq("rst_perf_cycles", d, perf_cycles[d], 0);
    chk_eq("rst_perf_chunks", d, perf_chunks[d], 0);
  endtask

  // Reference chunk list straight from the key-range arithmetic.
  task automatic do_start(input int d, output int n);
    longint unsigned step = longint'(1) << CL_TAB[d];
    longint unsigned km   = longint'(KM_TAB[d]);
    chunk_t c;
    n = 0;
    for (longint unsigned lo = 0; lo <= km; lo += step) begin
      c.lo = lo;
      c.hi = (lo + step - 1 > km) ? km : lo + step - 1;
      exp_chunk[d].push_back(c);
      n++;
    end
    @(negedge clk) start[d] = 1'b1;
    @(negedge clk) start[d] = 1'b0;
  endtask

  task automatic clear_cores();
    cm_mode[0] = 2;
    repeat (2) @(negedge clk);
    cm_mode[0] = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic hit_trial(input logic [NC-1:0] mask, input logic [NC*KW-1:0] keys,
                           input bit with_abort);
    int   n;
    int   win;
    res_t r;
    clear_cores();
    do_start(0, n);
    repeat ($urandom_range(0, 7)) @(negedge clk);
    win = -1;
    for (int i = NC - 1; i >= 0; i--) if (mask[i]) win = i;
    r.is_hit = 1'b1;
    r.key    = longint'(keys[win*KW +: KW]);
    r.core   = win;
    exp_res[0].push_back(r);
    hit[0]     = mask;
    hit_key[0] = keys;
    abort[0]   = with_abort;
    @(negedge clk);
    hit[0]     = '0;
    abort[0]   = 1'b0;
    hit_key[0] = {$urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    chk_eq("hit_kill_seen", 0, exp_res[0].size(), 0);
    exp_res[0].delete();
    exp_chunk[0].delete();
    // A later hit must leave the latched result alone.
    hit[0] = NC'(1) << $urandom_range(0, NC - 1);
    @(negedge clk);
    hit[0] = '0;
    repeat (2) @(negedge clk);
    chk_eq("late_hit_found", 0, found[0], 1);
    chk_eq("late_hit_key", 0, found_key[0], r.key);
    chk_eq("late_hit_core", 0, found_core[0], r.core);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int   n;
    int   t;
    res_t r;
    logic [NC*KW-1:0] keys;

    rst = 1'b1;
    for (int d = 0; d < ND; d++) begin
      start[d] = 1'b0; abort[d] = 1'b0; hit[d] = '0; hit_key[d] = '0; cm_mode[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) check_zero(d);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp-out and exhaust on each geometry (full, truncated, full-width space).
    for (int d = 0; d < ND; d++) begin
      cm_mode[d] = 1;
      repeat (2) @(negedge clk);
      if (d == 0) begin
        log_core.delete();
        log_cyc.delete();
      end
      do_start(d, n);
      t = 0;
      while (!exhausted[d] && t < 4000) begin
        @(negedge clk);
        t++;
      end
      chk_eq("exhausted", d, exhausted[d], 1);
      chk_eq("exh_found", d, found[d], 0);
      chk_eq("exh_busy", d, busy[d], 0);
      chk_eq("chunks_left", d, exp_chunk[d].size(), 0);
`ifdef KEY_DISPATCH_PERF_EN
      chk_eq("perf_chunks", d, perf_chunks[d], n);
`else
      chk_eq("perf_chunks", d, perf_chunks[d], 0);
`endif
      if (d == 0) begin
        chk_eq("ramp_loads", d, log_core.size() >= 4, 1);
        if (log_core.size() >= 4) begin
          for (int k = 0; k < 4; k++) begin
            chk_eq("ramp_core", d, log_core[k], k);
            chk_eq("ramp_cycle", d, log_cyc[k] - log_cyc[0], k);
          end
        end
      end
      cm_mode[d] = 0;
      repeat (2) @(negedge clk);
    end

    // Directed hits: single, simultaneous, hit racing an abort.
    keys = '0;
    keys[2*KW +: KW] = 24'h2A;
    hit_trial(4'b0100, keys, 1'b0);
    keys = '0;
    keys[1*KW +: KW] = 24'h15;
    keys[3*KW +: KW] = 24'h33;
    hit_trial(4'b1010, keys, 1'b0);
    keys = {$urandom, $urandom, $urandom};
    hit_trial(4'b0001, keys, 1'b1);

    // Random hit masks and keys.
    for (int k = 0; k < 6; k++) begin
      keys = {$urandom, $urandom, $urandom};
      hit_trial(NC'($urandom_range(1, 15)), keys, 1'b0);
    end

    // Abort mid-dispatch.
    for (int k = 0; k < 3; k++) begin
      clear_cores();
      do_start(0, n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      r.is_hit = 1'b0;
      r.key    = 0;
      r.core   = 0;
      exp_res[0].push_back(r);
      abort[0] = 1'b1;
      @(negedge clk);
      abort[0] = 1'b0;
      repeat (2) @(negedge clk);
      chk_eq("abort_kill_seen", 0, exp_res[0].size(), 0);
      chk_eq("abort_busy", 0, busy[0], 0);
      chk_eq("abort_found", 0, found[0], 0);
      chk_eq("abort_exhausted", 0, exhausted[0], 0);
      exp_res[0].delete();
      exp_chunk[0].delete();
    end

    // Asynchronous reset in the middle of a search.
    clear_cores();
    do_start(0, n);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) check_zero(d);
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < ND; d++) begin
      exp_chunk[d].delete();
      exp_res[d].delete();
    end
    repeat (3) @(negedge clk);
    chk_eq("post_rst_busy", 0, busy[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
